// File: rtl/data_demux_blk.sv
// Purpose : routes one input word to one of five holding slots chosen by a 3-bit index (0..4).
// Latency : 1 cycle from an accepted word to out_valid/out_data of its slot; dsel/in_ready combinational.
// Backpres: per slot; in_ready drops only while the addressed slot is full and not being acked.
//
// Ports
//   clk        rising-edge system clock
//   rst        synchronous, active-high reset (dominates accept and ack in the same cycle)
//   in_valid   input word/index present
//   in_dest    destination slot index 0..4; 5..7 are dropped and counted as errors
//   in_data    input word
//   in_ready   word accepted this cycle when in_valid && in_ready (independent of in_valid)
//   dsel       one-hot decode of in_dest, qualified by in_valid; zero for an illegal index
//   out_valid  slot i holds an unconsumed word
//   out_data   slot i word at [i*WIDTH +: WIDTH]
//   out_ack    consumer i takes slot i word; ignored while out_valid[i] is 0
//   err        one-cycle pulse after an illegal index was accepted and dropped
//   err_cnt    saturating (255) count of dropped illegal writes
//
// The decode and in_ready paths carry a gate delay (NAND_TIME, nominally 7ns) in the physical
// implementation; this model is zero-delay, so timing is left to the implementation constraints.

module data_demux_blk #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [2:0]           in_dest,
   input  logic [WIDTH-1:0]     in_data,
   output logic                 in_ready,
   output logic [4:0]           dsel,
   output logic [4:0]           out_valid,
   output logic [5*WIDTH-1:0]   out_data,
   input  logic [4:0]           out_ack,
   output logic                 err,
   output logic [7:0]           err_cnt
);

   localparam int NUM_SLOTS = 5;

   // Per-slot state encoding.
   localparam logic [0:0] SLOT_EMPTY = 1'b0;
   localparam logic [0:0] SLOT_FULL  = 1'b1;

   localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [0:0]       slot_state_q [NUM_SLOTS];
   logic [0:0]       slot_state_d [NUM_SLOTS];
   logic [WIDTH-1:0] slot_data_q  [NUM_SLOTS];
   logic [WIDTH-1:0] slot_data_d  [NUM_SLOTS];
   logic             err_q;
   logic             err_d;
   logic [7:0]       err_cnt_q;
   logic [7:0]       err_cnt_d;

   // ------------------------------------------------------------------
   // Decode and handshake
   // ------------------------------------------------------------------
   logic             dest_legal;
   logic [4:0]       dest_hit;    // unqualified one-hot of in_dest, zero when illegal
   logic [4:0]       slot_free;   // slot can take a word this cycle (empty or draining)
   logic [4:0]       slot_load;   // legal accept into slot i
   logic [4:0]       ack_eff;     // ack that actually consumes a word
   logic             accept;
   logic             drop;

   always_comb begin
      dest_legal = (in_dest < 3'd5);
      dest_hit   = '0;
      slot_free  = '0;
      ack_eff    = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         dest_hit[i]  = (in_dest == 3'(i));
         slot_free[i] = (slot_state_q[i] == SLOT_EMPTY) | out_ack[i];
         ack_eff[i]   = (slot_state_q[i] == SLOT_FULL) & out_ack[i];
      end

      dsel = dest_hit & {5{in_valid}};

      // Illegal indices are always taken so the source can never stall on a bad index.
      in_ready = ~dest_legal | (|(dest_hit & slot_free));

      accept    = in_valid & in_ready;
      slot_load = dsel & {5{in_ready}};
      drop      = accept & ~dest_legal;
   end

   // ------------------------------------------------------------------
   // Slot FSMs
   // ------------------------------------------------------------------
   always_comb begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
         slot_state_d[i] = slot_state_q[i];
         slot_data_d[i]  = slot_data_q[i];
         case (slot_state_q[i])
            SLOT_EMPTY: begin
               if (slot_load[i]) begin
                  slot_state_d[i] = SLOT_FULL;
                  slot_data_d[i]  = in_data;
               end
            end
            SLOT_FULL: begin
               // A load into a full slot only happens alongside its ack (pass-through):
               // the old word leaves, the new one lands, valid stays high.
               if (slot_load[i]) begin
                  slot_state_d[i] = SLOT_FULL;
                  slot_data_d[i]  = in_data;
               end else if (ack_eff[i]) begin
                  slot_state_d[i] = SLOT_EMPTY;
               end
            end
            default: begin
               slot_state_d[i] = SLOT_EMPTY;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Illegal-index error pulse and saturating counter
   // ------------------------------------------------------------------
   always_comb begin
      err_d     = drop;
      err_cnt_d = err_cnt_q;
      if (drop && (err_cnt_q != ERR_CNT_MAX)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_state_q[i] <= SLOT_EMPTY;
            slot_data_q[i]  <= '0;
         end
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_state_q[i] <= slot_state_d[i];
            slot_data_q[i]  <= slot_data_d[i];
         end
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   always_comb begin
      out_valid = '0;
      out_data  = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         out_valid[i]               = (slot_state_q[i] == SLOT_FULL);
         out_data[i*WIDTH +: WIDTH] = slot_data_q[i];
      end
   end

   assign err     = err_q;
   assign err_cnt = err_cnt_q;

   // ------------------------------------------------------------------
   // Structural invariants
   // ------------------------------------------------------------------
   dsel_onehot0_a : assert property (@(posedge clk) disable iff (rst) $onehot0(dsel));

   load_onehot0_a : assert property (@(posedge clk) disable iff (rst) $onehot0(slot_load));

   // A full slot is only ever overwritten while its consumer acks.
   no_overwrite_a : assert property (@(posedge clk) disable iff (rst)
                                     ((slot_load & out_valid) & ~out_ack) == 5'b00000);

   drop_no_load_a : assert property (@(posedge clk) disable iff (rst)
                                     drop |-> (slot_load == 5'b00000));

endmodule
